// File: rtl/coherent_cycle_averager.sv
// Coherent cycle averager: accumulates 2^K signal cycles of M points each,
// point by point, into an accumulator RAM, then streams out one averaged cycle.
module coherent_cycle_averager #(
  parameter int MAX_PTS = 2048,
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 48
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [15:0]              ptos_x_ciclo,
  input  logic [3:0]               log2_ciclos,
  input  logic                     data_valid,
  input  logic signed [DATA_W-1:0] data,
  input  logic                     zero_cross,
  output logic signed [DATA_W-1:0] avg_data,
  output logic                     avg_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     sync_error,
  output logic                     cfg_error
);

  localparam int AW = (MAX_PTS > 1) ? $clog2(MAX_PTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SYNC,
    S_ACCUM,
    S_READOUT,
    S_DONE
  } state_t;

  function automatic logic signed [ACC_W-1:0] f_sext(input logic signed [DATA_W-1:0] d);
    return ACC_W'(d);
  endfunction

  // Arithmetic shift floors toward minus infinity; the low DATA_W bits are kept.
  function automatic logic signed [DATA_W-1:0] f_avg(input logic signed [ACC_W-1:0] acc,
                                                     input logic [3:0] k);
    return DATA_W'(acc >>> k);
  endfunction

  state_t                   r_state;
  logic                     r_en_d;
  logic [15:0]              r_m_last;
  logic [15:0]              r_n_last;
  logic [15:0]              r_cycle;
  logic [3:0]               r_k;
  logic [AW-1:0]            r_idx;
  logic [AW-1:0]            r_rd_addr;
  logic                     r_ro_wait;
  logic                     r_rd_done;

  logic                     r_wr_vld_p0;
  logic [AW-1:0]            r_wr_addr_p0;
  logic signed [DATA_W-1:0] r_wr_data_p0;
  logic                     r_wr_first_p0;
  logic signed [ACC_W-1:0]  r_ram_q_p0;
  logic                     r_ro_vld_p0;
  logic                     r_ro_last_p0;
  logic                     r_ro_last_p1;

  logic signed [ACC_W-1:0]  r_mem [MAX_PTS];

  logic                     w_start;
  logic                     w_cfg_bad;
  logic                     w_abort;
  logic                     w_accept;
  logic                     w_idx_last;
  logic                     w_cyc_last;
  logic                     w_rd_last;
  logic [AW-1:0]            w_rd_addr;
  logic signed [ACC_W-1:0]  w_wr_data;

  assign w_start    = enable & ~r_en_d;
  assign w_cfg_bad  = (ptos_x_ciclo < 16'd2) || (ptos_x_ciclo > 16'(MAX_PTS));
  assign w_abort    = ~enable && ((r_state == S_WAIT_SYNC) || (r_state == S_ACCUM) ||
                                  (r_state == S_READOUT));
  assign w_accept   = enable && data_valid &&
                      ((r_state == S_ACCUM) || ((r_state == S_WAIT_SYNC) && zero_cross));
  assign w_idx_last = (16'(r_idx) == r_m_last);
  assign w_cyc_last = (r_cycle == r_n_last);
  assign w_rd_last  = (16'(r_rd_addr) == r_m_last);
  assign w_rd_addr  = (r_state == S_READOUT) ? r_rd_addr : r_idx;
  assign w_wr_data  = r_wr_first_p0 ? f_sext(r_wr_data_p0)
                                    : r_ram_q_p0 + f_sext(r_wr_data_p0);

  // Stage p0: RAM read and sample capture; stage p1: accumulate write-back.
  always_ff @(posedge clock) begin
    r_ram_q_p0 <= r_mem[w_rd_addr];
    if (r_wr_vld_p0) begin
      r_mem[r_wr_addr_p0] <= w_wr_data;
    end
    if (w_accept) begin
      r_wr_addr_p0  <= r_idx;
      r_wr_data_p0  <= data;
      r_wr_first_p0 <= (r_cycle == 16'd0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_en_d       <= 1'b0;
      r_m_last     <= '0;
      r_n_last     <= '0;
      r_cycle      <= '0;
      r_k          <= '0;
      r_idx        <= '0;
      r_rd_addr    <= '0;
      r_ro_wait    <= 1'b0;
      r_rd_done    <= 1'b0;
      r_wr_vld_p0  <= 1'b0;
      r_ro_vld_p0  <= 1'b0;
      r_ro_last_p0 <= 1'b0;
      r_ro_last_p1 <= 1'b0;
      avg_data     <= '0;
      avg_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sync_error   <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      r_en_d       <= enable;
      r_wr_vld_p0  <= w_accept;
      r_ro_vld_p0  <= 1'b0;
      r_ro_last_p0 <= 1'b0;
      // Stage p1: readout word leaves through the output register.
      r_ro_last_p1 <= r_ro_last_p0;
      avg_valid    <= r_ro_vld_p0;
      done         <= 1'b0;
      if (r_ro_vld_p0) begin
        avg_data <= f_avg(r_ram_q_p0, r_k);
      end

      if (w_abort) begin
        r_state   <= S_IDLE;
        busy      <= 1'b0;
        avg_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_m_last   <= ptos_x_ciclo - 16'd1;
              r_n_last   <= (16'd1 << log2_ciclos) - 16'd1;
              r_k        <= log2_ciclos;
              sync_error <= 1'b0;
              cfg_error  <= w_cfg_bad;
              if (!w_cfg_bad) begin
                r_idx   <= '0;
                r_cycle <= '0;
                busy    <= 1'b1;
                r_state <= S_WAIT_SYNC;
              end
            end
          end
          S_WAIT_SYNC: begin
            // M >= 2, so the sync sample can never also close a cycle.
            if (w_accept) begin
              r_idx   <= AW'(1);
              r_state <= S_ACCUM;
            end
          end
          S_ACCUM: begin
            if (w_accept) begin
              if (zero_cross && (r_idx != '0)) begin
                sync_error <= 1'b1;
              end
              if (w_idx_last) begin
                r_idx <= '0;
                if (w_cyc_last) begin
                  r_ro_wait <= 1'b1;
                  r_rd_done <= 1'b0;
                  r_rd_addr <= '0;
                  r_state   <= S_READOUT;
                end else begin
                  r_cycle <= r_cycle + 16'd1;
                end
              end else begin
                r_idx <= r_idx + AW'(1);
              end
            end
          end
          S_READOUT: begin
            // One idle clock lets the final accumulate write land before reads start.
            if (r_ro_wait) begin
              r_ro_wait <= 1'b0;
            end else if (!r_rd_done) begin
              r_ro_vld_p0  <= 1'b1;
              r_ro_last_p0 <= w_rd_last;
              if (w_rd_last) begin
                r_rd_done <= 1'b1;
              end else begin
                r_rd_addr <= r_rd_addr + AW'(1);
              end
            end
            if (avg_valid && r_ro_last_p1) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coherent_cycle_averager.sv
// Directed, table-driven bench for coherent_cycle_averager with hand-computed
// averages plus hand-written abort, reset and configuration-error sequences.
module tb_coherent_cycle_averager;

  localparam int DATA_W  = 32;
  localparam int ACC_W   = 48;
  localparam int MAX_PTS = 2048;

  typedef struct packed {
    int              m;
    int              k;
    int              pre_idx;
    int              gap;
    int              mode;
    int              zc_inj;
    int              exp_sync;
    logic [0:15][31:0] exp;
  } vec_t;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     enable;
  logic [15:0]              ptos_x_ciclo;
  logic [3:0]               log2_ciclos;
  logic                     data_valid;
  logic signed [DATA_W-1:0] data;
  logic                     zero_cross;
  logic signed [DATA_W-1:0] avg_data;
  logic                     avg_valid;
  logic                     busy;
  logic                     done;
  logic                     sync_error;
  logic                     cfg_error;

  coherent_cycle_averager #(
    .MAX_PTS(MAX_PTS),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .ptos_x_ciclo(ptos_x_ciclo),
    .log2_ciclos (log2_ciclos),
    .data_valid  (data_valid),
    .data        (data),
    .zero_cross  (zero_cross),
    .avg_data    (avg_data),
    .avg_valid   (avg_valid),
    .busy        (busy),
    .done        (done),
    .sync_error  (sync_error),
    .cfg_error   (cfg_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic signed [DATA_W-1:0] got[$];
  int done_cnt = 0;
  int first_v  = -1;
  int last_v   = -1;

  always @(negedge clock) begin
    if (avg_valid) begin
      got.push_back(avg_data);
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (done) done_cnt++;
  end

  vec_t vecs[8];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    done_cnt = 0;
    first_v  = -1;
    last_v   = -1;
  endtask

  function automatic int gen(input int mode, input int c, input int i);
    int t[8];
    t = '{10, -10, 3, -3, 12, -12, 4, -4};
    case (mode)
      0:       return 100 * i;
      1:       return t[c * 4 + i];
      default: return 10 * i - 50 + c;
    endcase
  endfunction

  function automatic vec_t mk(input int m, input int k, input int pre_idx, input int gap,
                              input int mode, input int zc_inj, input int exp_sync);
    vec_t v;
    v          = '0;
    v.m        = m;
    v.k        = k;
    v.pre_idx  = pre_idx;
    v.gap      = gap;
    v.mode     = mode;
    v.zc_inj   = zc_inj;
    v.exp_sync = exp_sync;
    return v;
  endfunction

  task automatic send(input int d, input logic zc, input int gap, output int t);
    data       = d;
    zero_cross = zc;
    data_valid = 1'b1;
    tick();
    t          = cyc;
    data_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      data       = 32'sd12345;
      zero_cross = 1'b1;
      tick();
    end
    zero_cross = 1'b0;
  endtask

  task automatic start_run(input int m, input int k);
    enable       = 1'b0;
    data_valid   = 1'b0;
    zero_cross   = 1'b0;
    ptos_x_ciclo = 16'(m);
    log2_ciclos  = 4'(k);
    tick();
    tick();
    enable = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    string nm;
    int    w;
    int    t;
    int    t_last;
    int    nc;
    logic  zc;
    nm = $sformatf("v%0d", id);
    clear_mon();
    start_run(v.m, v.k);
    w = 0;
    while (!busy && w < 10) begin
      tick();
      w++;
    end
    chk({nm, "_busy_rise"}, busy, 1);
    chk({nm, "_start_sync_clr"}, sync_error, 0);
    chk({nm, "_start_cfg_clr"}, cfg_error, 0);
    for (int j = 0; j < 2; j++) send(777, 1'b0, 0, t);
    if (v.pre_idx > 0) begin
      for (int i = v.pre_idx; i < v.m; i++) send(gen(v.mode, 0, i), 1'b0, v.gap, t);
    end
    nc     = 1 << v.k;
    t_last = 0;
    for (int c = 0; c < nc; c++) begin
      for (int i = 0; i < v.m; i++) begin
        zc = (i == 0) || ((c == 1) && (i == v.zc_inj));
        send(gen(v.mode, c, i), zc, v.gap, t);
        t_last = t;
      end
    end
    w = 0;
    while (done_cnt == 0 && w < v.m + 20) begin
      data       = 32'sd999;
      data_valid = 1'b1;
      zero_cross = w[0];
      tick();
      w++;
    end
    data_valid = 1'b0;
    zero_cross = 1'b0;
    tick();
    tick();
    tick();
    chk({nm, "_words"}, got.size(), v.m);
    for (int i = 0; i < v.m; i++) begin
      chk($sformatf("%s_avg%0d", nm, i), (i < got.size()) ? got[i] : 32'sh7fff_fff0,
          $signed(v.exp[i]));
    end
    chk({nm, "_first_lat"}, first_v - t_last, 3);
    chk({nm, "_last_lat"}, last_v - t_last, v.m + 2);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_sync_err"}, sync_error, v.exp_sync);
    chk({nm, "_cfg_err"}, cfg_error, 0);
    enable = 1'b0;
    tick();
  endtask

  initial begin
    int t;
    int busy_seen;
    int w;
    int bad_m[2];

    // Test table
    vecs[0] = mk(8, 2, 0, 0, 0, -1, 0);
    for (int j = 0; j < 8; j++) vecs[0].exp[j] = 32'(100 * j);
    vecs[1] = mk(4, 1, 0, 0, 1, -1, 0);
    vecs[1].exp[0] = 32'(11);
    vecs[1].exp[1] = 32'(-11);
    vecs[1].exp[2] = 32'(3);
    vecs[1].exp[3] = 32'(-4);
    vecs[2] = mk(8, 2, 5, 0, 0, -1, 0);
    for (int j = 0; j < 8; j++) vecs[2].exp[j] = 32'(100 * j);
    vecs[3] = mk(8, 1, 0, 0, 0, 3, 1);
    for (int j = 0; j < 8; j++) vecs[3].exp[j] = 32'(100 * j);
    vecs[4] = mk(16, 3, 0, 1, 2, -1, 0);
    for (int j = 0; j < 16; j++) vecs[4].exp[j] = 32'(10 * j - 47);
    vecs[5] = mk(16, 3, 0, 0, 2, -1, 0);
    for (int j = 0; j < 16; j++) vecs[5].exp[j] = 32'(10 * j - 47);
    vecs[6] = mk(4, 0, 0, 0, 1, -1, 0);
    vecs[6].exp[0] = 32'(10);
    vecs[6].exp[1] = 32'(-10);
    vecs[6].exp[2] = 32'(3);
    vecs[6].exp[3] = 32'(-3);
    vecs[7] = mk(2, 2, 0, 0, 2, -1, 0);
    vecs[7].exp[0] = 32'(-49);
    vecs[7].exp[1] = 32'(-39);

    reset        = 1'b1;
    enable       = 1'b0;
    ptos_x_ciclo = 16'd8;
    log2_ciclos  = 4'd2;
    data_valid   = 1'b0;
    data         = '0;
    zero_cross   = 1'b0;
    tick();
    tick();
    chk("rst_avg_data", avg_data, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sync_err", sync_error, 0);
    chk("rst_cfg_err", cfg_error, 0);
    reset = 1'b0;
    tick();

    // Illegal point counts
    bad_m[0] = 1;
    bad_m[1] = 4096;
    for (int b = 0; b < 2; b++) begin
      clear_mon();
      start_run(bad_m[b], 2);
      busy_seen = 0;
      for (int j = 0; j < 6; j++) begin
        data_valid = 1'b1;
        zero_cross = 1'b1;
        tick();
        if (busy) busy_seen = 1;
      end
      data_valid = 1'b0;
      zero_cross = 1'b0;
      chk($sformatf("cfg%0d_cfg_err", b), cfg_error, 1);
      chk($sformatf("cfg%0d_busy", b), busy_seen, 0);
      chk($sformatf("cfg%0d_words", b), got.size(), 0);
    end

    for (int v = 0; v < 8; v++) run_vec(vecs[v], v);

    // Enable dropped in the middle of accumulation
    clear_mon();
    start_run(8, 2);
    tick();
    for (int i = 0; i < 10; i++) send(gen(0, 0, i % 8), (i % 8) == 0, 0, t);
    enable = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_avg_valid", avg_valid, 0);
    for (int i = 0; i < 40; i++) send(gen(0, 0, i % 8), (i % 8) == 0, 0, t);
    chk("abort_done", done_cnt, 0);
    chk("abort_words", got.size(), 0);

    // Reset asserted during readout
    clear_mon();
    start_run(8, 1);
    tick();
    for (int i = 0; i < 16; i++) send(gen(0, 0, i % 8), (i % 8) == 0, 0, t);
    w = 0;
    while (!avg_valid && w < 10) begin
      tick();
      w++;
    end
    chk("rro_reached", avg_valid, 1);
    tick();
    reset = 1'b1;
    #1;
    chk("rro_avg_valid", avg_valid, 0);
    chk("rro_busy", busy, 0);
    chk("rro_avg_data", avg_data, 0);
    chk("rro_done", done, 0);
    enable = 1'b0;
    tick();
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("rro_no_done", done_cnt, 0);
    chk("rro_idle_busy", busy, 0);
    chk("rro_idle_valid", avg_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
